execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- EX stage of the 5-stage RV32 pipeline; sits directly upstream of the memory stage and drives its inputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM).
- Selects forwarded operands, executes the ALU operation and resolves branches (branch target, taken flag).
- Registers all memory-stage signals in the EX/MEM pipeline register; can insert a bubble.

Parameters:
DATA_W, 32, datapath width (ALU, PC, operands)
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RegWriteE  in  1  register write enable from decode
ALUSrcE  in  1  0: operand B = forwarded RD2; 1: operand B = Imm_Ext_E
MemWriteE  in  1  store enable
ResultSrcE  in  1  0: ALU result, 1: memory read data at writeback
BranchE  in  1  instruction is a conditional branch
BneE  in  1  0: BEQ semantics, 1: BNE semantics (valid only with BranchE)
ALUControlE  in  3  ALU opcode
RD1_E, RD2_E  in  DATA_W  register file read data
Imm_Ext_E  in  DATA_W  sign-extended immediate
RD_E  in  REG_AW  destination register
PCE, PCPlus4E  in  DATA_W  instruction PC and PC+4
ForwardA_E, ForwardB_E  in  2  forwarding selects from the hazard unit
ResultW  in  DATA_W  writeback result, used for forwarding
BubbleE  in  1  kill the instruction currently in EX
PCSrcE  out  1  branch taken (combinational)
PCTargetE  out  DATA_W  PCE + Imm_Ext_E (combinational)
RegWriteM, MemWriteM, ResultSrcM  out  1  registered controls
RD_M  out  REG_AW  registered destination register
PCPlus4M, WriteDataM, ALU_ResultM  out  DATA_W  registered data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0, every M output is 0. PCSrcE is forced to 0 while rst=0.
- Forwarding, same encoding for A and B:
  - 00: register value (RD1_E for A, RD2_E for B).
  - 01: ResultW.
  - 10: ALU_ResultM, the module's own registered output.
  - 11: reserved; treated as 00.
- Operand B: SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteDataM always captures forwarded B, never the immediate.
- ALUControlE encoding (all arithmetic mod 2^DATA_W):
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT, signed; result is 1 or 0, zero-extended
  - 110 SLL by SrcB[4:0]
  - 111 SRL (logical) by SrcB[4:0]
- Zero = (ALU result == 0).
- PCSrcE = BranchE & ~BubbleE & (Zero ^ BneE). Branches use SUB; decode guarantees ALUControlE = 001 when BranchE = 1.
- PCTargetE = PCE + Imm_Ext_E, wrap-around, no overflow flag.
- EX/MEM register, on every rising clk edge with rst=1:
  - All data fields capture their EX values.
  - Control fields capture their EX values, unless BubbleE=1; then RegWriteM, MemWriteM and ResultSrcM load 0.
  - Data fields under BubbleE are don't-care; the implementation loads them normally.
- Latency: exactly 1 cycle from E inputs to M outputs. No stall input; the stage advances every cycle.
- Back-to-back dependency: ForwardA_E=10 in cycle N+1 must see the ALU_ResultM registered at the end of cycle N.
- Shifts with SrcB[31:5] nonzero ignore the upper bits.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). The first edge after reset release captures the current E inputs.

Test Plan:
- Reset → hold rst=0, toggle clk 3 cycles with random E inputs → all M outputs 0, PCSrcE=0. Release rst with ADD 5+7, RegWriteE=1, RD_E=3 → next edge ALU_ResultM=12, RegWriteM=1, RD_M=3.
- ALU sweep, RD1=0xFFFFFFF0, Imm=0x10, ALUSrcE=1 → ADD=0x00000000, SUB=0xFFFFFFE0, SLT=1 (signed -16<16), SRL by 4 → 0x0FFFFFFF, SLL by 4 → 0xFFFFFF00, XOR=0xFFFFFFE0.
- Forwarding, ADD RD1=1,RD2=1 → ALU_ResultM=2:
  - Next cycle ForwardA_E=10, RD1_E=99, RD2_E=3, ADD → ALU_ResultM=5.
  - ForwardB_E=01, ResultW=0x40, MemWriteE=1, ALUSrcE=1 → WriteDataM=0x40.
- Branch, BEQ with RD1=RD2=7, PCE=0x100, Imm=0x20, SUB:
  - PCSrcE=1, PCTargetE=0x120.
  - Same operands with BneE=1 → PCSrcE=0.
  - BEQ with 7 vs 8 → PCSrcE=0.
- Bubble → BubbleE=1 on taken BEQ with RegWriteE=1, MemWriteE=1 → PCSrcE=0; next edge RegWriteM=0, MemWriteM=0, ResultSrcM=0.
- Async reset mid-stream → drive rst low between edges while RegWriteM=1 → RegWriteM and ALU_ResultM go 0 before the next clk edge.

Source files
------------

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of a 5-stage RV32 pipeline.
//
// Picks the forwarded operands, runs the ALU and resolves conditional
// branches (taken flag plus target). Every memory-stage signal is then
// held in the EX/MEM pipeline register. BubbleE kills the instruction in
// EX: no branch is taken and its control bits do not reach MEM.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   RegWriteE .. BneE        decode control bits for the instruction in EX
//   ALUControlE              ALU opcode
//   RD1_E, RD2_E, Imm_Ext_E  register operands and sign-extended immediate
//   RD_E, PCE, PCPlus4E      destination register, PC and PC+4
//   ForwardA_E, ForwardB_E   hazard-unit forwarding selects
//   ResultW                  writeback result, one of the forwarding sources
//   BubbleE                  kill the instruction in EX
//   PCSrcE, PCTargetE        branch taken / branch target (combinational)
//   *M                       EX/MEM pipeline register outputs

module execute_cycle #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic              BneE,
    input  logic [2:0]        ALUControlE,
    input  logic [DATA_W-1:0] RD1_E,
    input  logic [DATA_W-1:0] RD2_E,
    input  logic [DATA_W-1:0] Imm_Ext_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] PCPlus4E,
    input  logic [1:0]        ForwardA_E,
    input  logic [1:0]        ForwardB_E,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              BubbleE,
    output logic              PCSrcE,
    output logic [DATA_W-1:0] PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_AW-1:0] RD_M,
    output logic [DATA_W-1:0] PCPlus4M,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ALU_ResultM
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    logic              r_reg_write;
    logic              r_mem_write;
    logic              r_result_src;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [DATA_W-1:0] r_write_data;
    logic [DATA_W-1:0] r_alu_result;

    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_src_b;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_zero;

    // Forwarding select: the reserved code 11 falls back to the register value.
    always_comb begin
        case (ForwardA_E)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        case (ForwardB_E)
            2'b01:   w_fwd_b = ResultW;
            2'b10:   w_fwd_b = r_alu_result;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    // Shift amount uses only the low bits of operand B; upper bits are ignored.
    assign w_shamt = w_src_b[SH_W-1:0];

    always_comb begin
        w_alu_result = '0;
        case (ALUControlE)
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
            ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
            ALU_SLT: w_alu_result = {{(DATA_W-1){1'b0}},
                                     ($signed(w_src_a) < $signed(w_src_b))};
            ALU_SLL: w_alu_result = w_src_a << w_shamt;
            ALU_SRL: w_alu_result = w_src_a >> w_shamt;
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    // Branches always run SUB, so Zero means "operands equal"; BneE inverts it.
    // The rst term keeps the fetch stage from redirecting while held in reset.
    assign PCSrcE    = rst & BranchE & ~BubbleE & (w_zero ^ BneE);
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= '0;
            r_pc_plus4   <= '0;
            r_write_data <= '0;
            r_alu_result <= '0;
        end else begin
            // A bubble only has to clear the side-effecting controls; the data
            // fields load normally because nothing downstream consumes them.
            r_reg_write  <= RegWriteE  & ~BubbleE;
            r_mem_write  <= MemWriteE  & ~BubbleE;
            r_result_src <= ResultSrcE & ~BubbleE;
            r_rd         <= RD_E;
            r_pc_plus4   <= PCPlus4E;
            r_write_data <= w_fwd_b;
            r_alu_result <= w_alu_result;
        end
    end

    assign RegWriteM   = r_reg_write;
    assign MemWriteM   = r_mem_write;
    assign ResultSrcM  = r_result_src;
    assign RD_M        = r_rd;
    assign PCPlus4M    = r_pc_plus4;
    assign WriteDataM  = r_write_data;
    assign ALU_ResultM = r_alu_result;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed-vector bench for execute_cycle.
// Stimulus drives EX inputs on the falling edge and queues the hand-computed
// EX/MEM contents it expects. A monitor pops one entry per rising edge and
// compares it with the registered outputs. Combinational branch outputs are
// checked next to the stimulus.

module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, BneE, BubbleE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    execute_cycle #(.DATA_W(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .BneE        (BneE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .RD_E        (RD_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .ResultW     (ResultW),
        .BubbleE     (BubbleE),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
        logic        ctrl_only;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic push(input int tag, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] pc4, input logic [31:0] wd,
                        input logic [31:0] alu, input logic co);
        exp_t e;
        e.rw = rw; e.mw = mw; e.rs = rs; e.rd = rd;
        e.pc4 = pc4; e.wd = wd; e.alu = alu; e.ctrl_only = co; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: the register updates on every rising edge, so each edge presents
    // one new EX/MEM word to check against the oldest queued expectation.
    exp_t m_e;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk($sformatf("t%0d RegWriteM", m_e.tag),  {31'b0, RegWriteM},  {31'b0, m_e.rw});
            chk($sformatf("t%0d MemWriteM", m_e.tag),  {31'b0, MemWriteM},  {31'b0, m_e.mw});
            chk($sformatf("t%0d ResultSrcM", m_e.tag), {31'b0, ResultSrcM}, {31'b0, m_e.rs});
            if (!m_e.ctrl_only) begin
                chk($sformatf("t%0d RD_M", m_e.tag),        {27'b0, RD_M}, {27'b0, m_e.rd});
                chk($sformatf("t%0d PCPlus4M", m_e.tag),    PCPlus4M,      m_e.pc4);
                chk($sformatf("t%0d WriteDataM", m_e.tag),  WriteDataM,    m_e.wd);
                chk($sformatf("t%0d ALU_ResultM", m_e.tag), ALU_ResultM,   m_e.alu);
            end
        end
    end

    task automatic clr();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; BneE = 0; BubbleE = 0; ALUControlE = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 32'h4; ForwardA_E = 0; ForwardB_E = 0; ResultW = 0;
    endtask

    // Register-write ALU instruction, no forwarding. b is RD2 (and WriteDataM).
    task automatic alu_op(input int tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic src,
                          input logic [31:0] exp_alu);
        logic [4:0]  rd;
        logic [31:0] pc4;
        rd  = tag[4:0];
        pc4 = 32'h1000 + 32'(tag * 4);
        @(negedge clk);
        clr();
        RegWriteE = 1; ALUControlE = op; RD1_E = a; RD2_E = b;
        Imm_Ext_E = imm; ALUSrcE = src; RD_E = rd; PCPlus4E = pc4;
        push(tag, 1'b1, 1'b0, 1'b0, rd, pc4, b, exp_alu, 1'b0);
    endtask

    // Conditional branch (SUB). A bubbled branch also carries write controls
    // that must not reach MEM.
    task automatic br(input int tag, input logic bne, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pce, input logic [31:0] imm, input logic exp_taken,
                      input logic [31:0] exp_tgt, input logic [31:0] exp_alu, input logic bub);
        @(negedge clk);
        clr();
        BranchE = 1; BneE = bne; ALUControlE = 3'b001;
        RD1_E = a; RD2_E = b; PCE = pce; Imm_Ext_E = imm; BubbleE = bub;
        if (bub) begin
            RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1;
        end
        push(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'h4, b, exp_alu, bub);
        #1;
        chk($sformatf("t%0d PCSrcE", tag), {31'b0, PCSrcE}, {31'b0, exp_taken});
        chk($sformatf("t%0d PCTargetE", tag), PCTargetE, exp_tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        clr();

        // Held in reset with random inputs: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
            ALUSrcE = 1'($urandom); BranchE = 1'b1; BneE = 1'($urandom);
            ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = RD1_E;
            Imm_Ext_E = $urandom; RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = $urandom;
            ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom); ResultW = $urandom;
            push(i, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
            #1;
            chk($sformatf("rst%0d PCSrcE", i), {31'b0, PCSrcE}, 32'h0);
        end

        // Release: first edge captures ADD 5+7.
        @(negedge clk);
        clr();
        rst = 1'b1;
        RegWriteE = 1; RD1_E = 5; RD2_E = 7; RD_E = 3; PCPlus4E = 32'h8;
        push(10, 1'b1, 1'b0, 1'b0, 5'd3, 32'h8, 32'h7, 32'd12, 1'b0);

        // ALU sweep
        alu_op(20, 3'b000, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'h00000000);
        alu_op(21, 3'b001, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'hFFFFFFE0);
        alu_op(22, 3'b010, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'h00000010);
        alu_op(23, 3'b011, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'hFFFFFFF0);
        alu_op(24, 3'b100, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'hFFFFFFE0);
        alu_op(25, 3'b101, 32'hFFFFFFF0, 32'h55, 32'h10, 1'b1, 32'h00000001);
        alu_op(26, 3'b101, 32'h00000010, 32'h55, 32'hFFFFFFF0, 1'b1, 32'h00000000);
        alu_op(27, 3'b110, 32'hFFFFFFF0, 32'h55, 32'h4, 1'b1, 32'hFFFFFF00);
        alu_op(28, 3'b111, 32'hFFFFFFF0, 32'h55, 32'h4, 1'b1, 32'h0FFFFFFF);
        alu_op(29, 3'b111, 32'hFFFFFFF0, 32'h55, 32'h24, 1'b1, 32'h0FFFFFFF);
        alu_op(30, 3'b000, 32'hFFFFFFFF, 32'h2, 32'h0, 1'b0, 32'h00000001);
        alu_op(31, 3'b001, 32'h00000000, 32'h1, 32'h0, 1'b0, 32'hFFFFFFFF);

        // Forwarding
        alu_op(40, 3'b000, 32'd1, 32'd1, 32'h0, 1'b0, 32'd2);
        @(negedge clk);
        clr();
        RegWriteE = 1; ForwardA_E = 2'b10; RD1_E = 99; RD2_E = 3; RD_E = 4;
        push(41, 1'b1, 1'b0, 1'b0, 5'd4, 32'h4, 32'd3, 32'd5, 1'b0);

        @(negedge clk);
        clr();
        MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b01; ResultW = 32'h40;
        RD1_E = 1; RD2_E = 32'h77; Imm_Ext_E = 8;
        push(42, 1'b0, 1'b1, 1'b0, 5'd0, 32'h4, 32'h40, 32'd9, 1'b0);

        @(negedge clk);
        clr();
        RegWriteE = 1; ForwardA_E = 2'b01; ResultW = 32'h40; RD1_E = 32'h1234; RD2_E = 2; RD_E = 6;
        push(43, 1'b1, 1'b0, 1'b0, 5'd6, 32'h4, 32'd2, 32'h42, 1'b0);

        @(negedge clk);
        clr();
        RegWriteE = 1; ForwardA_E = 2'b11; ForwardB_E = 2'b11; ResultW = 32'h40;
        RD1_E = 10; RD2_E = 2; RD_E = 6;
        push(44, 1'b1, 1'b0, 1'b0, 5'd6, 32'h4, 32'd2, 32'd12, 1'b0);

        @(negedge clk);
        clr();
        RegWriteE = 1; ResultSrcE = 1; ALUControlE = 3'b001; ForwardB_E = 2'b10;
        RD1_E = 32'h100; RD2_E = 5; RD_E = 7;
        push(45, 1'b1, 1'b0, 1'b1, 5'd7, 32'h4, 32'd12, 32'hF4, 1'b0);

        // Branches
        br(50, 1'b0, 32'd7, 32'd7, 32'h100, 32'h20, 1'b1, 32'h120, 32'h0, 1'b0);
        br(51, 1'b1, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0, 32'h120, 32'h0, 1'b0);
        br(52, 1'b0, 32'd7, 32'd8, 32'h100, 32'h20, 1'b0, 32'h120, 32'hFFFFFFFF, 1'b0);
        br(53, 1'b1, 32'd7, 32'd8, 32'h100, 32'h20, 1'b1, 32'h120, 32'hFFFFFFFF, 1'b0);
        br(54, 1'b0, 32'd3, 32'd3, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10, 32'h0, 1'b0);

        // Bubble on a taken BEQ carrying write controls
        br(55, 1'b0, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0, 32'h120, 32'h0, 1'b1);
        alu_op(56, 3'b000, 32'd3, 32'd4, 32'h0, 1'b0, 32'd7);

        // Async reset between edges while RegWriteM=1
        @(negedge clk);
        chk("pre-reset RegWriteM", {31'b0, RegWriteM}, 32'h1);
        clr();
        BranchE = 1; ALUControlE = 3'b001; RD1_E = 7; RD2_E = 7;
        push(60, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("async RegWriteM", {31'b0, RegWriteM}, 32'h0);
        chk("async ALU_ResultM", ALU_ResultM, 32'h0);
        chk("async RD_M", {27'b0, RD_M}, 32'h0);
        chk("async PCSrcE", {31'b0, PCSrcE}, 32'h0);

        @(negedge clk);
        push(61, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);

        @(negedge clk);
        clr();
        rst = 1'b1;
        RegWriteE = 1; ALUControlE = 3'b100; RD1_E = 32'h20; RD2_E = 32'h22; RD_E = 1;
        push(62, 1'b1, 1'b0, 1'b0, 5'd1, 32'h4, 32'h22, 32'h2, 1'b0);

        @(negedge clk);
        clr();
        @(negedge clk);
        chk("queue drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
